// File: rtl/synapse_operand_feeder_pkg.sv
// Shared neurosynapse datapath definitions: FP32 width, feeder states and
// pointer sizing used by the operand feeder and its pair buffer.
package neuro_pkg;

  localparam int FP32_W = 32;

  typedef enum logic {
    LOAD  = 1'b0,
    ISSUE = 1'b1
  } feeder_state_e;

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/synapse_operand_feeder_if.sv
// Loader-side and multiplier-side handshake bundle of the operand feeder.
// The feeder attaches through the slave modport; the master modport is its environment.
interface synapse_operand_feeder_if
  import neuro_pkg::*;
#(
  parameter int DEPTH = 8
);
  localparam int PW = ptr_width(DEPTH);

  logic [FP32_W-1:0] load_activation;
  logic [FP32_W-1:0] load_weight;
  logic              load_last;
  logic              load_STB;
  logic              load_BUSY;

  logic [FP32_W-1:0] output_a;
  logic [FP32_W-1:0] output_b;
  logic              mult_input_STB;
  logic              mult_BUSY;
  logic              out_last;
  logic [PW-1:0]     pair_index;

  modport slave (
    input  load_activation, load_weight, load_last, load_STB, mult_BUSY,
    output load_BUSY, output_a, output_b, mult_input_STB, out_last, pair_index
  );

  modport master (
    output load_activation, load_weight, load_last, load_STB, mult_BUSY,
    input  load_BUSY, output_a, output_b, mult_input_STB, out_last, pair_index
  );

endinterface

// File: rtl/synapse_operand_feeder_buffer.sv
// DEPTH-entry store of packed {activation, weight} pairs: synchronous write,
// combinational read. Data is never reset; stale entries are never presented.
module operand_pair_buffer
  import neuro_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 2 * FP32_W,
  parameter int PW     = ptr_width(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [PW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [PW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/synapse_operand_feeder.sv
// Collects a burst of (activation, weight) pairs, then issues them in load
// order to the FP32 multiplier, tagging the final pair of the burst.
module synapse_operand_feeder
  import neuro_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  synapse_operand_feeder_if.slave bus
);

  localparam int              PW        = ptr_width(DEPTH);
  localparam logic [PW-1:0]   LAST_SLOT = PW'(DEPTH - 1);

  feeder_state_e       state;
  logic                issuing;
  logic [PW-1:0]       wr_ptr;
  logic [PW-1:0]       rd_ptr;
  logic [PW:0]         count;
  logic                accept;
  logic                xfer;
  logic                at_last;
  logic [2*FP32_W-1:0] rd_pair;

  assign accept  = (state == LOAD) && bus.load_STB;
  assign xfer    = issuing && !bus.mult_BUSY;
  assign at_last = ({1'b0, rd_ptr} == (count - (PW+1)'(1)));

  // issuing mirrors state == ISSUE so both handshake outputs come straight from a flop
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= LOAD;
      issuing <= 1'b0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (accept) begin
            wr_ptr <= wr_ptr + PW'(1);
            if (bus.load_last || (wr_ptr == LAST_SLOT)) begin
              count   <= {1'b0, wr_ptr} + (PW+1)'(1);
              rd_ptr  <= '0;
              state   <= ISSUE;
              issuing <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (xfer) begin
            if (at_last) begin
              wr_ptr  <= '0;
              state   <= LOAD;
              issuing <= 1'b0;
            end else begin
              rd_ptr <= rd_ptr + PW'(1);
            end
          end
        end
        default: begin
          state   <= LOAD;
          issuing <= 1'b0;
        end
      endcase
    end
  end

  operand_pair_buffer #(
    .DEPTH (DEPTH),
    .DATA_W(2 * FP32_W),
    .PW    (PW)
  ) u_buffer (
    .clk  (clk),
    .we   (accept),
    .waddr(wr_ptr),
    .wdata({bus.load_activation, bus.load_weight}),
    .raddr(rd_ptr),
    .rdata(rd_pair)
  );

  assign bus.load_BUSY      = issuing;
  assign bus.mult_input_STB = issuing;
  assign bus.out_last       = issuing && at_last;
  assign bus.pair_index     = rd_ptr;
  assign bus.output_a       = rd_pair[2*FP32_W-1:FP32_W];
  assign bus.output_b       = rd_pair[FP32_W-1:0];

endmodule

// File: tb/tb_synapse_operand_feeder.sv
// Scenario bench for synapse_operand_feeder: directed bursts plus randomized
// bursts checked against a queue-based model of load order and last tagging.
module tb_synapse_operand_feeder;

  localparam int DEPTH = 8;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  synapse_operand_feeder_if #(.DEPTH(DEPTH)) bus ();

  synapse_operand_feeder #(.DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one offered pair and advance to the next falling edge; STB stays up.
  task automatic push(input logic [31:0] a, input logic [31:0] w, input logic last);
    bus.load_activation = a;
    bus.load_weight     = w;
    bus.load_last       = last;
    bus.load_STB        = 1'b1;
    @(negedge clk);
  endtask

  task automatic load_idle();
    bus.load_STB  = 1'b0;
    bus.load_last = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (bus.load_BUSY !== 1'b0) begin errors++; $display("FAIL reset_load_busy: got %b want 0", bus.load_BUSY); end
    checks++;
    if (bus.mult_input_STB !== 1'b0) begin errors++; $display("FAIL reset_stb: got %b want 0", bus.mult_input_STB); end
    checks++;
    if (bus.pair_index !== 3'd0) begin errors++; $display("FAIL reset_index: got %0d want 0", bus.pair_index); end
    checks++;
    if (bus.out_last !== 1'b0) begin errors++; $display("FAIL reset_last: got %b want 0", bus.out_last); end
    rst = 1'b0;
  endtask

  task automatic test_single_pair();
    bus.mult_BUSY = 1'b0;
    push(32'h3F80_0000, 32'h4000_0000, 1'b1);
    load_idle();
    checks++;
    if (bus.mult_input_STB !== 1'b1) begin errors++; $display("FAIL single_stb: got %b want 1", bus.mult_input_STB); end
    checks++;
    if (bus.output_a !== 32'h3F80_0000) begin errors++; $display("FAIL single_a: got %h want 3f800000", bus.output_a); end
    checks++;
    if (bus.output_b !== 32'h4000_0000) begin errors++; $display("FAIL single_b: got %h want 40000000", bus.output_b); end
    checks++;
    if (bus.out_last !== 1'b1) begin errors++; $display("FAIL single_last: got %b want 1", bus.out_last); end
    checks++;
    if (bus.load_BUSY !== 1'b1) begin errors++; $display("FAIL single_load_busy: got %b want 1", bus.load_BUSY); end
    @(negedge clk);
    checks++;
    if (bus.mult_input_STB !== 1'b0) begin errors++; $display("FAIL single_stb_after: got %b want 0", bus.mult_input_STB); end
    checks++;
    if (bus.load_BUSY !== 1'b0) begin errors++; $display("FAIL single_load_busy_after: got %b want 0", bus.load_BUSY); end
  endtask

  task automatic test_three_pair_busy();
    logic [31:0] ea [3];
    logic [31:0] ew [3];
    int          hold;
    ea[0] = 32'h3F80_0000; ew[0] = 32'h4000_0000;
    ea[1] = 32'h4040_0000; ew[1] = 32'h3F00_0000;
    ea[2] = 32'h4000_0000; ew[2] = 32'h4000_0000;
    bus.mult_BUSY = 1'b0;
    for (int i = 0; i < 3; i++) push(ea[i], ew[i], (i == 2));
    load_idle();
    for (int i = 0; i < 3; i++) begin
      hold = (i == 0) ? 0 : 12;
      for (int c = 0; c <= hold; c++) begin
        checks++;
        if (bus.mult_input_STB !== 1'b1) begin errors++; $display("FAIL three_stb[%0d,%0d]: got %b want 1", i, c, bus.mult_input_STB); end
        checks++;
        if (bus.output_a !== ea[i] || bus.output_b !== ew[i]) begin
          errors++; $display("FAIL three_pair[%0d,%0d]: got %h/%h want %h/%h", i, c, bus.output_a, bus.output_b, ea[i], ew[i]);
        end
        checks++;
        if (bus.pair_index !== 3'(i)) begin errors++; $display("FAIL three_index[%0d,%0d]: got %0d want %0d", i, c, bus.pair_index, i); end
        checks++;
        if (bus.out_last !== (i == 2)) begin errors++; $display("FAIL three_last[%0d,%0d]: got %b want %b", i, c, bus.out_last, (i == 2)); end
        bus.mult_BUSY = (c < hold);
        @(negedge clk);
      end
    end
    checks++;
    if (bus.mult_input_STB !== 1'b0 || bus.load_BUSY !== 1'b0) begin
      errors++; $display("FAIL three_done: got stb=%b busy=%b want 0/0", bus.mult_input_STB, bus.load_BUSY);
    end
  endtask

  task automatic test_full_buffer();
    logic [31:0] ea [DEPTH];
    logic [31:0] ew [DEPTH];
    bus.mult_BUSY = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      ea[i] = 32'h4100_0000 + 32'(i);
      ew[i] = ~ea[i];
      checks++;
      if (bus.load_BUSY !== 1'b0) begin errors++; $display("FAIL full_load_ready[%0d]: got %b want 0", i, bus.load_BUSY); end
      push(ea[i], ew[i], 1'b0);
    end
    load_idle();
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (bus.mult_input_STB !== 1'b1 || bus.load_BUSY !== 1'b1) begin
        errors++; $display("FAIL full_issue_hs[%0d]: got stb=%b busy=%b want 1/1", i, bus.mult_input_STB, bus.load_BUSY);
      end
      checks++;
      if (bus.output_a !== ea[i] || bus.output_b !== ew[i]) begin
        errors++; $display("FAIL full_pair[%0d]: got %h/%h want %h/%h", i, bus.output_a, bus.output_b, ea[i], ew[i]);
      end
      checks++;
      if (bus.out_last !== (i == DEPTH - 1)) begin errors++; $display("FAIL full_last[%0d]: got %b want %b", i, bus.out_last, (i == DEPTH - 1)); end
      @(negedge clk);
    end
    checks++;
    if (bus.mult_input_STB !== 1'b0) begin errors++; $display("FAIL full_done: got stb=%b want 0", bus.mult_input_STB); end
  endtask

  task automatic test_load_backpressure();
    bus.mult_BUSY = 1'b0;
    push(32'h1111_1111, 32'h2222_2222, 1'b0);
    push(32'h3333_3333, 32'h4444_4444, 1'b1);
    // held pair offered throughout ISSUE
    bus.load_activation = 32'hAAAA_5555;
    bus.load_weight     = 32'h5555_AAAA;
    bus.load_last       = 1'b1;
    bus.load_STB        = 1'b1;
    checks++;
    if (bus.output_a !== 32'h1111_1111 || bus.load_BUSY !== 1'b1) begin
      errors++; $display("FAIL bp_pair0: got %h busy=%b want 11111111 busy=1", bus.output_a, bus.load_BUSY);
    end
    @(negedge clk);
    checks++;
    if (bus.output_a !== 32'h3333_3333 || bus.output_b !== 32'h4444_4444) begin
      errors++; $display("FAIL bp_pair1: got %h/%h want 33333333/44444444", bus.output_a, bus.output_b);
    end
    @(negedge clk);
    checks++;
    if (bus.mult_input_STB !== 1'b0 || bus.load_BUSY !== 1'b0) begin
      errors++; $display("FAIL bp_load_window: got stb=%b busy=%b want 0/0", bus.mult_input_STB, bus.load_BUSY);
    end
    @(negedge clk);
    load_idle();
    checks++;
    if (bus.mult_input_STB !== 1'b1 || bus.output_a !== 32'hAAAA_5555 || bus.output_b !== 32'h5555_AAAA || bus.out_last !== 1'b1) begin
      errors++; $display("FAIL bp_held_pair: got stb=%b %h/%h last=%b want 1 aaaa5555/5555aaaa 1",
                         bus.mult_input_STB, bus.output_a, bus.output_b, bus.out_last);
    end
    @(negedge clk);
    checks++;
    if (bus.mult_input_STB !== 1'b0) begin errors++; $display("FAIL bp_done: got stb=%b want 0", bus.mult_input_STB); end
  endtask

  task automatic test_reset_mid_issue();
    bus.mult_BUSY = 1'b0;
    push(32'hC000_0000, 32'h0000_0001, 1'b0);
    push(32'hC000_0001, 32'h0000_0002, 1'b0);
    push(32'hC000_0002, 32'h0000_0003, 1'b1);
    load_idle();
    @(negedge clk);
    checks++;
    if (bus.pair_index !== 3'd1 || bus.output_a !== 32'hC000_0001) begin
      errors++; $display("FAIL rmid_pair1: got idx=%0d a=%h want 1 c0000001", bus.pair_index, bus.output_a);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (bus.mult_input_STB !== 1'b0 || bus.load_BUSY !== 1'b0 || bus.pair_index !== 3'd0 || bus.out_last !== 1'b0) begin
      errors++; $display("FAIL rmid_after_rst: got stb=%b busy=%b idx=%0d last=%b want 0/0/0/0",
                         bus.mult_input_STB, bus.load_BUSY, bus.pair_index, bus.out_last);
    end
    push(32'h4280_0000, 32'hBF80_0000, 1'b1);
    load_idle();
    checks++;
    if (bus.mult_input_STB !== 1'b1 || bus.output_a !== 32'h4280_0000 || bus.output_b !== 32'hBF80_0000 ||
        bus.out_last !== 1'b1 || bus.pair_index !== 3'd0) begin
      errors++; $display("FAIL rmid_fresh: got stb=%b %h/%h last=%b idx=%0d want 1 42800000/bf800000 1 0",
                         bus.mult_input_STB, bus.output_a, bus.output_b, bus.out_last, bus.pair_index);
    end
    @(negedge clk);
    checks++;
    if (bus.mult_input_STB !== 1'b0) begin errors++; $display("FAIL rmid_done: got stb=%b want 0", bus.mult_input_STB); end
  endtask

  task automatic test_nan_passthrough();
    bus.mult_BUSY = 1'b0;
    push(32'h7FC0_0000, 32'h0000_0000, 1'b1);
    load_idle();
    checks++;
    if (bus.output_a !== 32'h7FC0_0000) begin errors++; $display("FAIL nan_a: got %h want 7fc00000", bus.output_a); end
    checks++;
    if (bus.output_b !== 32'h0000_0000) begin errors++; $display("FAIL nan_b: got %h want 00000000", bus.output_b); end
    @(negedge clk);
  endtask

  // Model: a burst is the list of offered pairs up to the first last-flag or the
  // DEPTH-th pair; it must come out in the same order, last tagged on the final one.
  task automatic test_random_bursts();
    logic [31:0] qa[$];
    logic [31:0] qw[$];
    int          n;
    int          idx;
    int          cycles;
    logic        bm;
    logic        want_last;
    for (int b = 0; b < 25; b++) begin
      qa.delete();
      qw.delete();
      n = $urandom_range(1, DEPTH);
      for (int i = 0; i < n; i++) begin
        repeat ($urandom_range(0, 2)) begin
          load_idle();
          bus.mult_BUSY = 1'($urandom_range(0, 1));
          @(negedge clk);
          checks++;
          if (bus.load_BUSY !== 1'b0 || bus.mult_input_STB !== 1'b0) begin
            errors++; $display("FAIL rnd_load_idle[%0d]: got busy=%b stb=%b want 0/0", b, bus.load_BUSY, bus.mult_input_STB);
          end
        end
        qa.push_back($urandom);
        qw.push_back($urandom);
        want_last = (i == n - 1) && !(n == DEPTH && $urandom_range(0, 1) == 1);
        push(qa[i], qw[i], want_last);
      end
      load_idle();
      idx = 0;
      cycles = 0;
      while (idx < n && cycles < 200) begin
        checks++;
        if (bus.mult_input_STB !== 1'b1 || bus.load_BUSY !== 1'b1) begin
          errors++; $display("FAIL rnd_issue_hs[%0d,%0d]: got stb=%b busy=%b want 1/1", b, idx, bus.mult_input_STB, bus.load_BUSY);
        end
        checks++;
        if (bus.output_a !== qa[idx] || bus.output_b !== qw[idx]) begin
          errors++; $display("FAIL rnd_pair[%0d,%0d]: got %h/%h want %h/%h", b, idx, bus.output_a, bus.output_b, qa[idx], qw[idx]);
        end
        checks++;
        if (bus.pair_index !== 3'(idx) || bus.out_last !== (idx == n - 1)) begin
          errors++; $display("FAIL rnd_tag[%0d,%0d]: got idx=%0d last=%b want %0d %b", b, idx, bus.pair_index, bus.out_last, idx, (idx == n - 1));
        end
        // junk offered on the load side must be ignored while issuing
        bus.load_STB        = 1'($urandom_range(0, 1));
        bus.load_activation = $urandom;
        bus.load_weight     = $urandom;
        bus.load_last       = 1'($urandom_range(0, 1));
        bm = 1'($urandom_range(0, 1));
        bus.mult_BUSY = bm;
        @(negedge clk);
        if (!bm) idx++;
        cycles++;
      end
      load_idle();
      bus.mult_BUSY = 1'b0;
      checks++;
      if (idx != n) begin errors++; $display("FAIL rnd_timeout[%0d]: got %0d issued want %0d", b, idx, n); end
      checks++;
      if (bus.mult_input_STB !== 1'b0 || bus.load_BUSY !== 1'b0) begin
        errors++; $display("FAIL rnd_done[%0d]: got stb=%b busy=%b want 0/0", b, bus.mult_input_STB, bus.load_BUSY);
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    bus.load_activation = '0;
    bus.load_weight     = '0;
    bus.load_last       = 1'b0;
    bus.load_STB        = 1'b0;
    bus.mult_BUSY       = 1'b0;
    test_reset();
    test_single_pair();
    test_three_pair_busy();
    test_full_buffer();
    test_load_backpressure();
    test_reset_mid_issue();
    test_nan_passthrough();
    test_random_bursts();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
